// File: rtl/adc_capture_buf_if.sv
// adc_capture_buf_if
//   Groups the FIFO read-side signals and the playback valid/ready stream of
//   the ADC snapshot buffer.
//   master : the capture buffer (drives fifo_rd_en and the cap_* stream)
//   slave  : the environment (FIFO plus correction stage)
//   fifo_rd_cnt   FIFO read-side word count
//   fifo_empty    FIFO empty flag
//   fifo_data_out FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    registered FIFO read strobe
//   cap_data      playback sample, channel 0 in the LSBs
//   cap_valid     playback sample valid
//   cap_ready     correction stage accepts the sample
//   cap_last      sample from the final RAM address
interface adc_capture_buf_if #(
  parameter int DATA_W = 12,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 14
) ();
  logic [CNT_W-1:0]         fifo_rd_cnt;
  logic                     fifo_empty;
  logic [NUM_CH*DATA_W-1:0] fifo_data_out;
  logic                     fifo_rd_en;
  logic [NUM_CH*DATA_W-1:0] cap_data;
  logic                     cap_valid;
  logic                     cap_ready;
  logic                     cap_last;

  modport master (
    input  fifo_rd_cnt, fifo_empty, fifo_data_out, cap_ready,
    output fifo_rd_en, cap_data, cap_valid, cap_last
  );

  modport slave (
    output fifo_rd_cnt, fifo_empty, fifo_data_out, cap_ready,
    input  fifo_rd_en, cap_data, cap_valid, cap_last
  );
endinterface

// File: rtl/adc_capture_buf.sv
// adc_capture_buf
//   ADC snapshot buffer. On arm it waits for the receive FIFO to reach
//   START_LEVEL, drains exactly DEPTH multi-channel samples into RAM, then
//   replays them over a valid/ready stream, once or in a continuous loop.
//   rd_clk     capture/playback clock
//   rd_rst_n   asynchronous active-low reset
//   arm        single-cycle start request (honoured in IDLE/DONE)
//   abort      return to IDLE on the next edge, wins over arm
//   loop_mode  0 = play once, 1 = loop until abort; latched on accepted arm
//   busy       high in WAIT_LEVEL, CAPTURE or PLAYBACK
//   done       high in DONE
//   bus        FIFO read side and playback stream (adc_capture_buf_if)
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   S_IDLE     | waiting for arm
//   S_WAIT     | armed, waiting for fifo_rd_cnt >= START_LEVEL
//   S_CAP      | reading DEPTH words from the FIFO into RAM
//   S_PLAY     | replaying RAM to the correction stage
//   S_DONE     | one-shot playback finished, RAM retained
module adc_capture_buf #(
  parameter int DATA_W      = 12,
  parameter int NUM_CH      = 4,
  parameter int DEPTH       = 8192,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int CNT_W       = 14,
  parameter int START_LEVEL = 8191
) (
  input  logic rd_clk,
  input  logic rd_rst_n,
  input  logic arm,
  input  logic abort,
  input  logic loop_mode,
  output logic busy,
  output logic done,
  adc_capture_buf_if.master bus
);

  localparam int W = NUM_CH * DATA_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_PLAY = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LEVEL_C   = CNT_W'(START_LEVEL);

  logic [2:0]        state_q, state_d;
  logic              loop_q, loop_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic              wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] pb_addr_q, pb_addr_d;
  logic              pb_stop_q, pb_stop_d;
  logic              ram_vld_q, ram_vld_d;
  logic              ram_last_q, ram_last_d;
  logic              v0_q, v0_d, v1_q, v1_d;
  logic              l0_q, l0_d, l1_q, l1_d;
  logic [W-1:0]      d0_q, d0_d, d1_q, d1_d;

  logic [W-1:0]      mem [DEPTH];
  logic [W-1:0]      ram_data_q;

  logic              pop_now;
  logic [ADDR_W:0]   cnt_next;
  logic              mem_we;
  logic              rd_issue;
  logic              pop;
  logic              push;
  logic [1:0]        fill;

  always_comb begin
    state_d    = state_q;
    loop_d     = loop_q;
    rd_en_d    = 1'b0;
    rd_cnt_d   = rd_cnt_q;
    wr_pend_d  = 1'b0;
    wr_addr_d  = wr_addr_q;
    pb_addr_d  = pb_addr_q;
    pb_stop_d  = pb_stop_q;
    ram_vld_d  = 1'b0;
    ram_last_d = ram_last_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    l0_d       = l0_q;
    l1_d       = l1_q;
    d0_d       = d0_q;
    d1_d       = d1_q;
    mem_we     = 1'b0;
    rd_issue   = 1'b0;

    // A strobe only pops the FIFO if the FIFO is not empty on that edge,
    // so a strobe landing on an empty cycle is simply retried.
    pop_now  = rd_en_q && !bus.fifo_empty;
    cnt_next = rd_cnt_q + {{ADDR_W{1'b0}}, pop_now};

    pop  = v0_q && bus.cap_ready;
    push = ram_vld_q;
    fill = {1'b0, v0_q} + {1'b0, v1_q} + {1'b0, ram_vld_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_d   = S_WAIT;
          loop_d    = loop_mode;
          rd_cnt_d  = '0;
          wr_addr_d = '0;
          pb_addr_d = '0;
          pb_stop_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (bus.fifo_rd_cnt >= LEVEL_C) state_d = S_CAP;
      end
      S_CAP: begin
        rd_cnt_d  = cnt_next;
        wr_pend_d = pop_now;
        rd_en_d   = !bus.fifo_empty && (cnt_next < DEPTH_C);
        if (wr_pend_q) begin
          mem_we = 1'b1;
          if (wr_addr_q == LAST_ADDR) begin
            wr_addr_d = '0;
            state_d   = S_PLAY;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      S_PLAY: begin
        // Credit check: buffered + in-flight words, minus the one leaving
        // this cycle, must leave room in the 2-entry output buffer.
        rd_issue = !pb_stop_q && ((fill < 2'd2) || ((fill == 2'd2) && pop));
        if (rd_issue) begin
          ram_vld_d  = 1'b1;
          ram_last_d = (pb_addr_q == LAST_ADDR);
          if (pb_addr_q == LAST_ADDR) begin
            pb_addr_d = '0;
            pb_stop_d = !loop_q;
          end else begin
            pb_addr_d = pb_addr_q + 1'b1;
          end
        end
        if (pop && l0_q && !loop_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Output buffer: entry 0 drives cap_data, entry 1 is the skid slot.
    case ({pop, push})
      2'b01: begin
        if (!v0_q) begin
          v0_d = 1'b1;
          d0_d = ram_data_q;
          l0_d = ram_last_q;
        end else begin
          v1_d = 1'b1;
          d1_d = ram_data_q;
          l1_d = ram_last_q;
        end
      end
      2'b10: begin
        if (v1_q) begin
          d0_d = d1_q;
          l0_d = l1_q;
          v1_d = 1'b0;
        end else begin
          v0_d = 1'b0;
        end
      end
      2'b11: begin
        if (v1_q) begin
          d0_d = d1_q;
          l0_d = l1_q;
          d1_d = ram_data_q;
          l1_d = ram_last_q;
        end else begin
          d0_d = ram_data_q;
          l0_d = ram_last_q;
        end
      end
      default: ;
    endcase

    if (abort) begin
      state_d   = S_IDLE;
      rd_en_d   = 1'b0;
      wr_pend_d = 1'b0;
      ram_vld_d = 1'b0;
      v0_d      = 1'b0;
      v1_d      = 1'b0;
      mem_we    = 1'b0;
      rd_issue  = 1'b0;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q    <= S_IDLE;
      loop_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_cnt_q   <= '0;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      pb_addr_q  <= '0;
      pb_stop_q  <= 1'b0;
      ram_vld_q  <= 1'b0;
      ram_last_q <= 1'b0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      l0_q       <= 1'b0;
      l1_q       <= 1'b0;
      d0_q       <= '0;
      d1_q       <= '0;
    end else begin
      state_q    <= state_d;
      loop_q     <= loop_d;
      rd_en_q    <= rd_en_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      pb_addr_q  <= pb_addr_d;
      pb_stop_q  <= pb_stop_d;
      ram_vld_q  <= ram_vld_d;
      ram_last_q <= ram_last_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      l0_q       <= l0_d;
      l1_q       <= l1_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
    end
  end

  // Snapshot RAM: no reset, synchronous one-cycle read.
  always_ff @(posedge rd_clk) begin
    if (mem_we)   mem[wr_addr_q] <= bus.fifo_data_out;
    if (rd_issue) ram_data_q     <= mem[pb_addr_q];
  end

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.cap_data   = d0_q;
  assign bus.cap_valid  = v0_q;
  assign bus.cap_last   = v0_q & l0_q;
  assign busy = (state_q == S_WAIT) || (state_q == S_CAP) || (state_q == S_PLAY);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_adc_capture_buf.sv
module tb_adc_capture_buf;

  localparam int DATA_W = 12;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 14;
  localparam int DEPTH  = 16;
  localparam int FWORDS = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic arm, abort, loop_mode;
  logic busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  // FIFO model state
  int   rp;
  int   fifo_base;
  logic fifo_clr;
  logic empty_mask;
  logic cnt_force_en;
  int   cnt_force;

  adc_capture_buf_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  adc_capture_buf #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH),
    .CNT_W(CNT_W), .START_LEVEL(10)
  ) dut (
    .rd_clk(clk), .rd_rst_n(rst_n), .arm(arm), .abort(abort),
    .loop_mode(loop_mode), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [NUM_CH*DATA_W-1:0] exp_word(input int v);
    logic [DATA_W-1:0] t;
    t = DATA_W'(v);
    return {t, t, t, t};
  endfunction

  assign bus.fifo_empty  = empty_mask || (rp >= FWORDS);
  assign bus.fifo_rd_cnt = cnt_force_en ? CNT_W'(cnt_force) : CNT_W'(FWORDS - rp);

  always @(posedge clk) begin
    if (fifo_clr) begin
      rp <= 0;
    end else if (bus.fifo_rd_en && !bus.fifo_empty) begin
      bus.fifo_data_out <= exp_word(fifo_base + rp);
      rp <= rp + 1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One arm-capture-playback run. Expected sample i is base + (i % DEPTH).
  task automatic run_scn(input int base, input bit lp, input int nx, input bit tog_empty,
                         input bit rnd_ready, input bit hold9, input bit chk_timing);
    int s, rd_n, first_rd, last_rd, xi, first_x, last_x;
    logic prev_stall;
    logic [NUM_CH*DATA_W-1:0] prev_data;
    fifo_base = base;
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
    cnt_force_en = hold9;
    cnt_force = 9;
    arm = 1'b1;
    loop_mode = lp;
    step();
    arm = 1'b0;
    loop_mode = 1'b0;
    check_val("busy_after_arm", 64'(busy), 64'd1);
    s = 0; rd_n = 0; first_rd = -1; last_rd = -1; xi = 0; first_x = -1; last_x = -1;
    prev_stall = 1'b0;
    prev_data = '0;
    while (xi < nx && s < 3000) begin
      step();
      s++;
      if (hold9 && s == 30) begin
        check_val("wait_no_rd_en", 64'(rd_n), 64'd0);
        check_val("wait_busy", 64'(busy), 64'd1);
        cnt_force = 10;
      end
      empty_mask = tog_empty && (s % 3 == 0);
      if (bus.fifo_rd_en) begin
        rd_n++;
        if (first_rd < 0) first_rd = s;
        last_rd = s;
      end
      bus.cap_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall)
        check_val("stall_hold", {15'd0, bus.cap_valid, bus.cap_data}, {15'd0, 1'b1, prev_data});
      if (bus.cap_valid && bus.cap_ready) begin
        check_val("xfer_data", 64'(bus.cap_data), 64'(exp_word(base + (xi % DEPTH))));
        check_val("xfer_last", 64'(bus.cap_last), 64'((xi % DEPTH) == DEPTH - 1));
        if (first_x < 0) first_x = s;
        last_x = s;
        xi++;
      end
      prev_stall = bus.cap_valid && !bus.cap_ready;
      prev_data = bus.cap_data;
    end
    empty_mask = 1'b0;
    check_val("xfer_count", 64'(xi), 64'(nx));
    if (!tog_empty) check_val("rd_en_pulses", 64'(rd_n), 64'(DEPTH));
    if (!rnd_ready) check_val("no_bubble_span", 64'(last_x - first_x), 64'(nx - 1));
    if (chk_timing) begin
      check_val("first_rd_en_cycle", 64'(first_rd), 64'd2);
      check_val("rd_en_consecutive", 64'(last_rd - first_rd), 64'(DEPTH - 1));
      check_val("first_valid_cycle", 64'(first_x), 64'd21);
    end
    if (!lp) begin
      step();
      check_val("done_after_last", 64'(done), 64'd1);
      check_val("busy_after_last", 64'(busy), 64'd0);
      check_val("valid_after_last", 64'(bus.cap_valid), 64'd0);
    end else begin
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_val("loop_abort_busy", 64'(busy), 64'd0);
      check_val("loop_abort_valid", 64'(bus.cap_valid), 64'd0);
      check_val("loop_abort_last", 64'(bus.cap_last), 64'd0);
    end
    cnt_force_en = 1'b0;
    bus.cap_ready = 1'b1;
  endtask

  initial begin
    int s, rd_n;
    rst_n = 1'b0;
    arm = 1'b0; abort = 1'b0; loop_mode = 1'b0;
    fifo_clr = 1'b1; fifo_base = 0; empty_mask = 1'b0;
    cnt_force_en = 1'b0; cnt_force = 0;
    bus.cap_ready = 1'b1;
    repeat (3) step();
    check_val("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check_val("rst_cap_data", 64'(bus.cap_data), 64'd0);
    check_val("rst_cap_valid", 64'(bus.cap_valid), 64'd0);
    check_val("rst_cap_last", 64'(bus.cap_last), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    fifo_clr = 1'b0;
    step();

    run_scn(0, 1'b0, 16, 1'b0, 1'b0, 1'b0, 1'b1);   // basic one-shot
    run_scn(0, 1'b0, 16, 1'b0, 1'b0, 1'b1, 1'b0);   // level held below threshold
    run_scn(0, 1'b0, 16, 1'b1, 1'b0, 1'b0, 1'b0);   // FIFO empty toggling
    run_scn(0, 1'b0, 16, 1'b0, 1'b1, 1'b0, 1'b0);   // random back-pressure
    run_scn(0, 1'b1, 40, 1'b0, 1'b0, 1'b0, 1'b0);   // loop playback

    // Abort partway through capture.
    fifo_base = 50;
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    s = 0; rd_n = 0;
    while (rd_n < 7 && s < 200) begin
      step();
      s++;
      if (bus.fifo_rd_en) rd_n++;
    end
    check_val("abort_reached_rd7", 64'(rd_n), 64'd7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_val("abort_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_done", 64'(done), 64'd0);
    rd_n = 0;
    repeat (5) begin
      step();
      if (bus.fifo_rd_en) rd_n++;
    end
    check_val("abort_idle_no_rd", 64'(rd_n), 64'd0);

    run_scn(100, 1'b0, 16, 1'b0, 1'b0, 1'b0, 1'b1); // fresh capture after abort

    // arm and abort together: abort wins.
    arm = 1'b1;
    abort = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b0;
    check_val("arm_abort_busy", 64'(busy), 64'd0);
    check_val("arm_abort_done", 64'(done), 64'd0);
    step();
    check_val("arm_abort_stay_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
